// File: rtl/mux_pkg.sv
// Shared types and helpers for the pipelined N-way selector.
package mux_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } mux_state_e;

  function automatic int sel_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_n_sel.sv
// Combinational N:1 select with out-of-range flag.
module mux_n
  import mux_pkg::*;
#(
  parameter  int DW = 32,
  parameter  int N  = 5,
  localparam int SW = sel_width(N)
) (
  input  logic [N*DW-1:0] in_data,
  input  logic [SW-1:0]   sel,
  output logic [DW-1:0]   data,
  output logic            err
);

  always_comb begin
    data = '0;
    err  = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (sel == SW'(k)) begin
        data = in_data[k*DW +: DW];
        err  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_n_pipe.sv
// N-way selector with a registered output and a 2-entry skid buffer.
module mux_n_pipe
  import mux_pkg::*;
#(
  parameter  int DW = 32,
  parameter  int N  = 5,
  localparam int SW = sel_width(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*DW-1:0] in_data,
  input  logic [SW-1:0]   in_sel,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [DW-1:0]   out_data,
  output logic            out_err,
  input  logic            out_ready,
  output logic            out_valid
);

  mux_state_e      state_q, state_d;
  logic [DW-1:0]   main_data_q, main_data_d;
  logic            main_err_q, main_err_d;
  logic [DW-1:0]   skid_data_q, skid_data_d;
  logic            skid_err_q, skid_err_d;
  logic [DW-1:0]   sel_data;
  logic            sel_err;
  logic            push, pop;

  mux_n #(.DW(DW), .N(N)) u_sel (
    .in_data (in_data),
    .sel     (in_sel),
    .data    (sel_data),
    .err     (sel_err)
  );

  // Handshake outputs come from the state register only.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_data_q;
  assign out_err   = main_err_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_err_d  = main_err_q;
    skid_data_d = skid_data_q;
    skid_err_d  = skid_err_q;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          state_d     = BUSY;
          main_data_d = sel_data;
          main_err_d  = sel_err;
        end
      end
      BUSY: begin
        if (push && pop) begin
          main_data_d = sel_data;
          main_err_d  = sel_err;
        end else if (push) begin
          state_d     = FULL;
          skid_data_d = sel_data;
          skid_err_d  = sel_err;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_d     = BUSY;
          main_data_d = skid_data_q;
          main_err_d  = skid_err_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_err_q  <= 1'b0;
      skid_data_q <= '0;
      skid_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_err_q  <= main_err_d;
      skid_data_q <= skid_data_d;
      skid_err_q  <= skid_err_d;
    end
  end

endmodule

// File: tb/tb_mux_n_pipe.sv
// Directed and scoreboard checks for mux_n_pipe (N=5/DW=32 and N=12/DW=8).
module tb_mux_n_pipe;

  logic         clk = 1'b0;
  logic         rst;

  logic [159:0] in_data;
  logic [2:0]   in_sel;
  logic         in_valid, in_ready;
  logic [31:0]  out_data;
  logic         out_err, out_valid, out_ready;

  logic [95:0]  r_in_data;
  logic [3:0]   r_in_sel;
  logic         r_in_valid, r_in_ready;
  logic [7:0]   r_out_data;
  logic         r_out_err, r_out_valid, r_out_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_n_pipe #(.DW(32), .N(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .out_ready (out_ready),
    .out_valid (out_valid)
  );

  mux_n_pipe #(.DW(8), .N(12)) dut_r (
    .clk       (clk),
    .rst       (rst),
    .in_data   (r_in_data),
    .in_sel    (r_in_sel),
    .in_valid  (r_in_valid),
    .in_ready  (r_in_ready),
    .out_data  (r_out_data),
    .out_err   (r_out_err),
    .out_ready (r_out_ready),
    .out_valid (r_out_valid)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [8:0]  sb[$];
  logic [8:0]  exp_beat;
  logic [31:0] exp_w;
  logic        push_r, pop_r;
  int          sel_list[8] = '{0, 1, 2, 3, 4, 0, 1, 2};
  int          s;
  int          drained;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_sel = '0;
    out_ready = 1'b1;
    r_in_valid = 1'b0;
    r_in_sel = '0;
    r_in_data = '0;
    r_out_ready = 1'b0;
    for (int k = 0; k < 5; k++) in_data[k*32 +: 32] = 32'h1000_0000 + k;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // basic select
    in_sel = 3'd3;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("basic_valid", 64'(out_valid), 64'd1);
    chk("basic_data", 64'(out_data), 64'h1000_0003);
    chk("basic_err", 64'(out_err), 64'd0);
    tick();
    chk("basic_drained", 64'(out_valid), 64'd0);

    // select sweep 0..7, back to back
    for (int i = 0; i < 8; i++) begin
      in_sel = 3'(i);
      in_valid = 1'b1;
      tick();
      exp_w = (i < 5) ? 32'h1000_0000 + 32'(i) : 32'h0;
      chk($sformatf("sweep_data_%0d", i), 64'(out_data), 64'(exp_w));
      chk($sformatf("sweep_err_%0d", i), 64'(out_err), (i >= 5) ? 64'd1 : 64'd0);
      chk($sformatf("sweep_valid_%0d", i), 64'(out_valid), 64'd1);
    end

    // back to back stream
    for (int i = 0; i < 8; i++) begin
      in_sel = 3'(sel_list[i]);
      in_valid = 1'b1;
      tick();
      chk($sformatf("b2b_data_%0d", i), 64'(out_data),
          64'h1000_0000 + 64'(sel_list[i]));
      chk($sformatf("b2b_in_ready_%0d", i), 64'(in_ready), 64'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("b2b_empty", 64'(out_valid), 64'd0);

    // stall and skid
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_sel = 3'd1;
    tick();
    chk("stall_rdy_after1", 64'(in_ready), 64'd1);
    chk("stall_data1", 64'(out_data), 64'h1000_0001);
    in_sel = 3'd2;
    tick();
    chk("stall_rdy_after2", 64'(in_ready), 64'd0);
    chk("stall_hold_a", 64'(out_data), 64'h1000_0001);
    in_sel = 3'd4;
    tick();
    chk("stall_hold_b", 64'(out_data), 64'h1000_0001);
    chk("stall_hold_rdy", 64'(in_ready), 64'd0);
    chk("stall_hold_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("drain_data2", 64'(out_data), 64'h1000_0002);
    chk("drain_rdy", 64'(in_ready), 64'd1);
    chk("drain_valid2", 64'(out_valid), 64'd1);
    tick();
    chk("drain_empty", 64'(out_valid), 64'd0);

    // error beat passes through skid
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_sel = 3'd0;
    tick();
    in_sel = 3'd6;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("skid_err_data", 64'(out_data), 64'd0);
    chk("skid_err_flag", 64'(out_err), 64'd1);
    tick();

    // reset while full
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_sel = 3'd0;
    tick();
    in_sel = 3'd3;
    tick();
    chk("pre_rst_full", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_data", 64'(out_data), 64'd0);
    chk("midrst_err", 64'(out_err), 64'd0);
    chk("midrst_rdy", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    tick();
    chk("midrst_no_ghost", 64'(out_valid), 64'd0);

    // push during reset is discarded
    rst = 1'b1;
    in_valid = 1'b1;
    in_sel = 3'd2;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("rst_push_dropped", 64'(out_valid), 64'd0);

    // randomised scoreboard on N=12, DW=8
    for (int c = 0; c < 3000; c++) begin
      r_in_data = {$urandom, $urandom, $urandom};
      r_in_sel = 4'($urandom_range(0, 15));
      r_in_valid = ($urandom_range(0, 3) != 0);
      r_out_ready = ($urandom_range(0, 2) != 0);
      chk("r_in_ready", 64'(r_in_ready), (sb.size() < 2) ? 64'd1 : 64'd0);
      chk("r_out_valid", 64'(r_out_valid), (sb.size() > 0) ? 64'd1 : 64'd0);
      push_r = r_in_valid && r_in_ready;
      pop_r = r_out_valid && r_out_ready;
      if (pop_r && sb.size() > 0) begin
        exp_beat = sb.pop_front();
        chk("r_beat", {55'd0, r_out_err, r_out_data}, {55'd0, exp_beat});
      end
      if (push_r) begin
        s = int'(r_in_sel);
        if (s < 12) sb.push_back({1'b0, r_in_data[s*8 +: 8]});
        else sb.push_back(9'h100);
      end
      tick();
    end
    r_in_valid = 1'b0;
    r_out_ready = 1'b1;
    drained = 0;
    while (sb.size() > 0 && drained < 10) begin
      if (r_out_valid) begin
        exp_beat = sb.pop_front();
        chk("r_drain", {55'd0, r_out_err, r_out_data}, {55'd0, exp_beat});
      end
      tick();
      drained++;
    end
    chk("r_sb_empty", 64'(sb.size()), 64'd0);
    chk("r_final_valid", 64'(r_out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_n_pipe.md
# mux_n_pipe

Parametrised N-way data selector with one registered output stage and a valid/ready handshake on both sides. It generalises the fixed 5:1 combinational select mux to arbitrary input count and width. It also flags out-of-range selects and decouples upstream from downstream stalls with a 2-entry skid buffer. It sits on the RV32 datapath wherever a wide select (writeback source, forwarding source, load/store unit result) must be retimed without losing throughput.

## Interface

Parameters:
- `DW`, 32, data width of each input and of the output.
- `N`, 5, number of selectable inputs; legal range is N ≥ 2.
- `SW`, `$clog2(N)`, select width; this is a derived localparam and is not overridden.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_data` in N*DW: flattened inputs; input k occupies bits `[k*DW +: DW]`.
- `in_sel` in SW: index of the input to forward.
- `in_valid` in 1: the upstream transfer is offered.
- `in_ready` out 1: the block can accept a transfer this cycle.
- `out_data` out DW: the selected word, registered.
- `out_err` out 1: `in_sel` was ≥ N for this beat; `out_data` is 0 for that beat.
- `out_valid` out 1: `out_data` and `out_err` hold a beat.
- `out_ready` in 1: downstream accepts the beat this cycle.

## Operation

- Push is `in_valid && in_ready`. Pop is `out_valid && out_ready`.
- On push, the selection is evaluated in the same cycle:
  - sel < N: data = input[sel], err = 0.
  - sel ≥ N (only possible when N is not a power of two): data = 0, err = 1.
- The selected {data, err} is captured as one beat.
- Storage:
  - Main register drives the outputs.
  - Skid register holds one further beat.
- FSM states: EMPTY, BUSY (main valid), FULL (main and skid valid).
  - EMPTY: push → BUSY and main loads the beat.
  - BUSY:
    - push & pop → BUSY, and main loads the new beat.
    - push & !pop → FULL, and skid loads the new beat.
    - pop & !push → EMPTY.
    - neither → BUSY, hold.
  - FULL:
    - pop → BUSY, and main loads from skid.
    - no pop → hold.
    - No push is possible in FULL.
- `out_valid` = (state ≠ EMPTY).
- `in_ready` = (state ≠ FULL), decoded from the state register only. It has no combinational path from `out_ready`.
- Beats leave in acceptance order. No beat is dropped or duplicated.
- `in_data` and `in_sel` are don't-care when `in_valid` = 0.

## Timing

- Latency: a beat pushed at edge t appears on `out_data`/`out_err` with `out_valid` = 1 from t+1.
- Throughput: one beat per cycle while `out_ready` = 1.
- Stall:
  - With `out_ready` low, at most one further beat is accepted, into the skid.
  - `in_ready` then falls on the next cycle.
- Hold rule: while `out_valid` && !`out_ready`, `out_data` and `out_err` are stable.
- Recovery: the first cycle after a pop from FULL has `in_ready` = 1.
- Reset, sampled at the edge:
  - state = EMPTY, `out_valid` = 0, `out_data` = 0, `out_err` = 0, skid contents = 0.
  - `in_ready` = 1 from the first cycle after reset.
  - A push presented in a reset cycle is discarded.
  - Reset mid-stream drops all stored beats.
- Push and pop in the same cycle are legal in BUSY only, and produce no bubble.

## Structure

- Shared package `mux_pkg`:
  - state enum `mux_state_e` {EMPTY, BUSY, FULL}.
  - helper function `sel_width(N)`.
- Sub-module `mux_n`: purely combinational N:1 select with range check.
  - Parameters: DW, N.
  - Outputs: data and err.
  - Instantiated once on the input side.
- Top level: FSM, main register and skid register, with `mux_n` feeding them.

## Test plan

1. Basic select, N=5, DW=32:
   - Stimulus: inputs k = 32'h1000_000k, sel = 3, valid for one cycle, `out_ready` = 1.
   - Response: next cycle `out_valid` = 1, `out_data` = 32'h1000_0003, `out_err` = 0.
2. Out-of-range select, N=5:
   - Stimulus: sel = 3'd6.
   - Response: `out_data` = 0, `out_err` = 1.
   - Also sweep sel = 0..7 and check err = 1 exactly for sel 5..7.
3. Back-to-back:
   - Stimulus: 8 consecutive beats with sel = 0,1,2,3,4,0,1,2 and `out_ready` = 1.
   - Response: 8 outputs on 8 consecutive cycles, in order; `in_ready` stays 1.
4. Stall/skid:
   - Stimulus: `out_ready` = 0 while streaming.
   - Response:
     - Exactly 2 beats are accepted.
     - `in_ready` = 0 in the cycle after the second push.
     - Outputs stay stable.
     - After raising `out_ready`, both beats drain in order and `in_ready` returns to 1 on the cycle after the first pop.
5. Reset mid-operation:
   - Stimulus: assert `rst` for one cycle while FULL.
   - Response: next cycle `out_valid` = 0, `out_data` = 0, `in_ready` = 1; the stored beats never appear.
6. Parameter sweep:
   - Configurations: N = 2, 8, 12 with DW = 8, 64.
   - Stimulus: randomised valid/ready.
   - Response: a scoreboard confirms order and data, err set only for sel ≥ N, and no loss or duplication over 10k beats.
